booth_mult_seq: RTL and testbench

//   Sequential radix-4 Booth multiplier control and accumulate stage for signed WIDTH x WIDTH operands.

---
 rtl/booth_mult_seq.sv | 156 +++++++++++++++
 tb/tb_booth_mult_seq.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/booth_mult_seq.sv
// Sequential radix-4 Booth multiplier: latches signed operands, feeds Booth triplets to an
// external booth_encoder and accumulates its shifted partial products into a 2*WIDTH product.

module booth_encoder #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0]   x,
    input  logic [2:0]         operand,
    output logic [2*WIDTH-1:0] partial_p
);

    logic [2*WIDTH-1:0] x_ext;
    logic [2*WIDTH-1:0] x_two;

    assign x_ext = {{WIDTH{x[WIDTH-1]}}, x};
    assign x_two = {x_ext[2*WIDTH-2:0], 1'b0};

    // Triplet {b[2k+1], b[2k], b[2k-1]} selects 0, +-A or +-2A.
    always_comb begin
        partial_p = {(2*WIDTH){1'b0}};
        case (operand)
            3'b000:  partial_p = {(2*WIDTH){1'b0}};
            3'b001:  partial_p = x_ext;
            3'b010:  partial_p = x_ext;
            3'b011:  partial_p = x_two;
            3'b100:  partial_p = (~x_two) + {{(2*WIDTH-1){1'b0}}, 1'b1};
            3'b101:  partial_p = (~x_ext) + {{(2*WIDTH-1){1'b0}}, 1'b1};
            3'b110:  partial_p = (~x_ext) + {{(2*WIDTH-1){1'b0}}, 1'b1};
            3'b111:  partial_p = {(2*WIDTH){1'b0}};
            default: partial_p = {(2*WIDTH){1'b0}};
        endcase
    end

endmodule

module booth_mult_seq #(
    parameter int WIDTH = 8,
    parameter int STEPS = WIDTH / 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [WIDTH-1:0]     enc_x,
    output logic [2:0]           enc_operand,
    input  logic [2*WIDTH-1:0]   enc_partial_p
);

    localparam int SW = $clog2(STEPS + 1);
    localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;

    state_t             state_r;
    logic [SW-1:0]      step_r;
    logic [WIDTH-1:0]   a_r;
    logic [WIDTH-1:0]   b_r;
    logic [2*WIDTH-1:0] acc_r;
    logic [2*WIDTH-1:0] product_r;
    logic               busy_r;
    logic               done_r;

    logic [SW:0]        shamt_s;
    logic [WIDTH:0]     b_ext_s;
    logic [WIDTH:0]     b_shift_s;
    logic [2:0]         triplet_s;
    logic [2*WIDTH-1:0] addend_s;
    logic [2*WIDTH-1:0] sum_s;

    // Step k weighs its partial product by 4^k; B[-1] is the appended zero below bit 0.
    assign shamt_s  = {step_r, 1'b0};
    assign b_ext_s  = {b_r, 1'b0};
    assign b_shift_s = b_ext_s >> shamt_s;
    assign addend_s = enc_partial_p << shamt_s;
    assign sum_s    = acc_r + addend_s;

    // Triplet is only presented while running so the encoder yields zero otherwise.
    always_comb begin
        triplet_s = 3'b000;
        if (state_r == RUN) begin
            triplet_s = b_shift_s[2:0];
        end else begin
            triplet_s = 3'b000;
        end
    end

    // Control FSM, operand latches, accumulator and registered handshake outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            step_r    <= {SW{1'b0}};
            a_r       <= {WIDTH{1'b0}};
            b_r       <= {WIDTH{1'b0}};
            acc_r     <= {(2*WIDTH){1'b0}};
            product_r <= {(2*WIDTH){1'b0}};
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    done_r <= 1'b0;
                    if (start) begin
                        a_r     <= multiplicand;
                        b_r     <= multiplier;
                        acc_r   <= {(2*WIDTH){1'b0}};
                        step_r  <= {SW{1'b0}};
                        busy_r  <= 1'b1;
                        state_r <= RUN;
                    end else begin
                        busy_r  <= 1'b0;
                        state_r <= IDLE;
                    end
                end
                RUN: begin
                    acc_r  <= sum_s;
                    step_r <= step_r + SW'(1);
                    busy_r <= 1'b1;
                    if (step_r == LAST_STEP) begin
                        product_r <= sum_s;
                        done_r    <= 1'b1;
                        state_r   <= DONE;
                    end else begin
                        done_r    <= 1'b0;
                        state_r   <= RUN;
                    end
                end
                DONE: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    state_r <= IDLE;
                end
                default: begin
                    done_r  <= 1'b0;
                    busy_r  <= 1'b0;
                    step_r  <= {SW{1'b0}};
                    state_r <= IDLE;
                end
            endcase
        end
    end

    assign busy        = busy_r;
    assign done        = done_r;
    assign product     = product_r;
    assign enc_x       = a_r;
    assign enc_operand = triplet_s;

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed bench for booth_mult_seq with the booth_encoder attached; table vectors plus
// hand-written sequences for back-to-back starts, mid-multiply reset and idle hold.

module tb_booth_mult_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  multiplicand;
    logic [7:0]  multiplier;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic [7:0]  enc_x;
    logic [2:0]  enc_operand;
    logic [15:0] enc_partial_p;

    int nvec;
    int nerr;

    booth_mult_seq #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .start(start),
        .multiplicand(multiplicand), .multiplier(multiplier),
        .busy(busy), .done(done), .product(product),
        .enc_x(enc_x), .enc_operand(enc_operand), .enc_partial_p(enc_partial_p)
    );

    booth_encoder #(.WIDTH(8)) enc (
        .x(enc_x), .operand(enc_operand), .partial_p(enc_partial_p)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] p;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        start = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_product", 32'(product), 32'd0);
        chk("rst_enc_operand", 32'(enc_operand), 32'd0);
        rst = 1'b0;
    endtask

    // One op with a single-cycle start; optional check of the four triplets.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic [15:0] p,
                          input logic chk_trip, input logic [11:0] trips);
        @(negedge clk);
        start = 1'b1;
        multiplicand = a;
        multiplier = b;
        @(negedge clk);
        start = 1'b0;
        multiplicand = 8'h00;
        multiplier = 8'h00;
        chk("busy_run", 32'(busy), 32'd1);
        chk("enc_x", 32'(enc_x), 32'(a));
        for (int k = 0; k < 4; k++) begin
            if (chk_trip) begin
                chk("enc_operand_step", 32'(enc_operand), 32'(trips[11-3*k -: 3]));
            end
            chk("done_early", 32'(done), 32'd0);
            @(negedge clk);
        end
        chk("done_pulse", 32'(done), 32'd1);
        chk("busy_done", 32'(busy), 32'd1);
        chk("product", 32'(product), 32'(p));
        @(negedge clk);
        chk("done_width", 32'(done), 32'd0);
        chk("busy_idle", 32'(busy), 32'd0);
        chk("product_hold", 32'(product), 32'(p));
    endtask

    logic [7:0]  seq_a [18];
    logic [7:0]  seq_b [18];
    logic [15:0] hold_p;

    initial begin
        nvec = 0;
        nerr = 0;
        rst = 1'b1;
        start = 1'b0;
        multiplicand = 8'h00;
        multiplier = 8'h00;

        vecs[0]  = '{a: 8'hA7, b: 8'h03, p: 16'hFEF5};
        vecs[1]  = '{a: 8'h80, b: 8'h80, p: 16'h4000};
        vecs[2]  = '{a: 8'h7F, b: 8'h80, p: 16'hC080};
        vecs[3]  = '{a: 8'h00, b: 8'hFF, p: 16'h0000};
        vecs[4]  = '{a: 8'h7F, b: 8'h7F, p: 16'h3F01};
        vecs[5]  = '{a: 8'h01, b: 8'hFF, p: 16'hFFFF};
        vecs[6]  = '{a: 8'hFF, b: 8'hFF, p: 16'h0001};
        vecs[7]  = '{a: 8'h05, b: 8'hFA, p: 16'hFFE2};
        vecs[8]  = '{a: 8'h80, b: 8'h7F, p: 16'hC080};
        vecs[9]  = '{a: 8'h12, b: 8'h34, p: 16'h03A8};
        vecs[10] = '{a: 8'hFF, b: 8'h80, p: 16'h0080};

        // Reset state.
        do_reset();

        // -89 * -89 with triplets 110, 011, 100, 101.
        run_op(8'hA7, 8'hA7, 16'h1EF1, 1'b1, {3'b110, 3'b011, 3'b100, 3'b101});

        for (int i = 0; i < 11; i++) begin
            do_reset();
            run_op(vecs[i].a, vecs[i].b, vecs[i].p, 1'b0, 12'h000);
        end

        // Start held high; only the operands present at accept edges 0, 6, 12 matter.
        do_reset();
        for (int i = 0; i < 18; i++) begin
            seq_a[i] = 8'(8'h35 + 8'(i * 29));
            seq_b[i] = 8'(8'hC1 + 8'(i * 53));
        end
        seq_a[0] = 8'hA7;  seq_b[0] = 8'hA7;
        seq_a[6] = 8'h12;  seq_b[6] = 8'h34;
        seq_a[12] = 8'h80; seq_b[12] = 8'h80;
        for (int i = 0; i < 18; i++) begin
            @(negedge clk);
            if (i > 0) begin
                chk("b2b_busy", 32'(busy), ((i % 6) != 0) ? 32'd1 : 32'd0);
                chk("b2b_done", 32'(done), ((i % 6) == 5) ? 32'd1 : 32'd0);
            end
            if (i == 5)  chk("b2b_product0", 32'(product), 32'h1EF1);
            if (i == 11) chk("b2b_product1", 32'(product), 32'h03A8);
            if (i == 17) chk("b2b_product2", 32'(product), 32'h4000);
            start = 1'b1;
            multiplicand = seq_a[i];
            multiplier = seq_b[i];
        end
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during step 2; the prior product (0x4000) must be cleared.
        start = 1'b1;
        multiplicand = 8'hA7;
        multiplier = 8'hA7;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_product", 32'(product), 32'd0);
        chk("abort_enc_operand", 32'(enc_operand), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("abort_no_done", 32'(done), 32'd0);
        end
        run_op(8'h7F, 8'h7F, 16'h3F01, 1'b0, 12'h000);

        // Idle hold after done.
        hold_p = 16'h3F01;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle_product", 32'(product), 32'(hold_p));
            chk("idle_busy", 32'(busy), 32'd0);
            chk("idle_enc_operand", 32'(enc_operand), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
